// File: rtl/vgachargen_apb_bridge_if.sv
// APB4 bus bundle between the host fabric and the VGA character generator bridge.
interface vgachargen_apb_bridge_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [15:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/vgachargen_apb_bridge.sv
// APB4 slave owning port A of the character map, colour map and RW glyph table.
// Optional feature: define VGACHARGEN_APB_PSLVERR_EN to report decode errors on pslverr_o.
module vgachargen_apb_bridge #(
  parameter int CH_MAP_ADDR_WIDTH = 12,
  parameter int CH_MAP_DEPTH      = 2400,
  parameter int CH_T_ADDR_WIDTH   = 7,
  parameter int CH_T_DATA_WIDTH   = 128
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  vgachargen_apb_bridge_if.slave       apb,

  output logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr_o,
  output logic [CH_T_ADDR_WIDTH:0]     ch_map_data_o,
  output logic                         ch_map_wen_o,
  input  logic [CH_T_ADDR_WIDTH:0]     ch_map_data_i,

  output logic [CH_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                   col_map_data_o,
  output logic                         col_map_wen_o,
  input  logic [7:0]                   col_map_data_i,

  output logic [CH_T_ADDR_WIDTH-1:0]   ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_o,
  output logic                         ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    RMW_MERGE,
    MAP_WR,
    ERR,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REGION_CH_MAP  = 2'b00,
    REGION_COL_MAP = 2'b01,
    REGION_GLYPH   = 2'b10,
    REGION_INVALID = 2'b11
  } region_t;

  localparam logic [11:0] MAP_DEPTH_IDX = 12'(CH_MAP_DEPTH);

  state_t        state;
  region_t       region_q;
  logic [1:0]    word_q;
  logic [31:0]   pwdata_q;
  logic [3:0]    pstrb_q;
  logic          write_q;

  logic [31:0]   prdata_q;
  logic          pready_q;
  logic          pslverr_q;

  // Setup-phase decode, straight off the bus
  logic                       setup;
  region_t                    setup_region;
  logic [11:0]                map_index;
  logic [CH_T_ADDR_WIDTH-1:0] glyph_index;
  logic [1:0]                 word_index;
  logic                       decode_err;
  logic                       unused_paddr;

  assign setup        = apb.psel_i && !apb.penable_i;
  assign setup_region = region_t'(apb.paddr_i[15:14]);
  assign map_index    = apb.paddr_i[13:2];
  assign glyph_index  = apb.paddr_i[4 +: CH_T_ADDR_WIDTH];
  assign word_index   = apb.paddr_i[3:2];
  assign unused_paddr = ^apb.paddr_i[1:0];

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    decode_err = 1'b0;
    case (setup_region)
      REGION_CH_MAP,
      REGION_COL_MAP: decode_err = (map_index >= MAP_DEPTH_IDX);
      REGION_GLYPH:   decode_err = |apb.paddr_i[13:11];
      default:        decode_err = 1'b1;
    endcase
  end

  // Read-modify-write merge: the glyph word read back this cycle with strobed bytes replaced.
  logic [CH_T_DATA_WIDTH-1:0] rmw_data;

  always_comb begin
    rmw_data = ch_t_rw_data_i;
    for (int b = 0; b < 4; b++) begin
      if (pstrb_q[b]) begin
        rmw_data[int'(word_q) * 32 + b * 8 +: 8] = pwdata_q[b * 8 +: 8];
      end
    end
  end

  // The merged word only exists during the single write-enable cycle; zero otherwise.
  assign ch_t_rw_data_o = ch_t_rw_wen_o ? rmw_data : '0;

  assign apb.prdata_o  = prdata_q;
  assign apb.pready_o  = pready_q;
  assign apb.pslverr_o = pslverr_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state          <= IDLE;
      region_q       <= REGION_CH_MAP;
      word_q         <= '0;
      pwdata_q       <= '0;
      pstrb_q        <= '0;
      write_q        <= 1'b0;
      prdata_q       <= '0;
      pready_q       <= 1'b0;
      pslverr_q      <= 1'b0;
      ch_map_addr_o  <= '0;
      ch_map_data_o  <= '0;
      ch_map_wen_o   <= 1'b0;
      col_map_addr_o <= '0;
      col_map_data_o <= '0;
      col_map_wen_o  <= 1'b0;
      ch_t_rw_addr_o <= '0;
      ch_t_rw_wen_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make every write enable a one-cycle pulse unless re-armed below.
      ch_map_wen_o  <= 1'b0;
      col_map_wen_o <= 1'b0;
      ch_t_rw_wen_o <= 1'b0;

      case (state)
        IDLE: begin
          if (setup) begin
            region_q <= setup_region;
            word_q   <= word_index;
            pwdata_q <= apb.pwdata_i;
            pstrb_q  <= apb.pstrb_i;
            write_q  <= apb.pwrite_i;

            case (setup_region)
              REGION_CH_MAP: begin
                ch_map_addr_o <= CH_MAP_ADDR_WIDTH'(map_index);
                ch_map_data_o <= apb.pwdata_i[CH_T_ADDR_WIDTH:0];
              end
              REGION_COL_MAP: begin
                col_map_addr_o <= CH_MAP_ADDR_WIDTH'(map_index);
                col_map_data_o <= apb.pwdata_i[7:0];
              end
              REGION_GLYPH: ch_t_rw_addr_o <= glyph_index;
              default: ;
            endcase

            if (decode_err) begin
              state <= ERR;
            end else if (!apb.pwrite_i || setup_region == REGION_GLYPH) begin
              state <= RD_ADDR;
            end else begin
              // Map write: the enable is armed here so it is live for the whole of T1.
              state <= MAP_WR;
              if (apb.pstrb_i[0]) begin
                if (setup_region == REGION_CH_MAP) ch_map_wen_o  <= 1'b1;
                else                               col_map_wen_o <= 1'b1;
              end
            end
          end
        end

        MAP_WR: begin
          if (!apb.psel_i) begin
            state <= IDLE;
          end else begin
            pready_q <= 1'b1;
            state    <= RESP;
          end
        end

        ERR: begin
          if (!apb.psel_i) begin
            state <= IDLE;
          end else begin
            pready_q <= 1'b1;
`ifdef VGACHARGEN_APB_PSLVERR_EN
            pslverr_q <= 1'b1;
`endif
            state    <= RESP;
          end
        end

        RD_ADDR: begin
          if (!apb.psel_i) begin
            state <= IDLE;
          end else if (write_q) begin
            ch_t_rw_wen_o <= 1'b1;
            state         <= RMW_MERGE;
          end else begin
            state <= RD_CAP;
          end
        end

        RD_CAP: begin
          if (!apb.psel_i) begin
            state <= IDLE;
          end else begin
            case (region_q)
              REGION_CH_MAP:  prdata_q <= 32'(ch_map_data_i);
              REGION_COL_MAP: prdata_q <= 32'(col_map_data_i);
              REGION_GLYPH:   prdata_q <= ch_t_rw_data_i[int'(word_q) * 32 +: 32];
              default:        prdata_q <= '0;
            endcase
            pready_q <= 1'b1;
            state    <= RESP;
          end
        end

        RMW_MERGE: begin
          if (!apb.psel_i) begin
            state <= IDLE;
          end else begin
            pready_q <= 1'b1;
            state    <= RESP;
          end
        end

        RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
